square_pwm_gen: RTL and testbench

//   Parametrised square/PWM waveform generator for the function generator datapath.

---
 rtl/square_pwm_gen.sv | 99 +++++++++
 tb/tb_square_pwm_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/square_pwm_gen.sv
// Square/PWM generator that tracks a shared phase counter and alternates between two levels.
// Config is double-buffered and applied only at period boundaries, so the output never glitches.
module square_pwm_gen #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] count_clk,
  input  logic          cfg_load,
  input  logic [CW-1:0] duty,
  input  logic [W-1:0]  level_hi,
  input  logic [W-1:0]  level_lo,
  input  logic          invert,
  output logic [W-1:0]  out_square,
  output logic          edge_rise,
  output logic          edge_fall
);

  localparam logic [W-1:0]  MID      = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  HI_DEF   = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]  LO_DEF   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DUTY_DEF = {1'b1, {(CW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] duty_s, duty_a, duty_n;
  logic [W-1:0]  hi_s, lo_s, hi_a, lo_a, hi_n, lo_n, hi_eff, lo_eff;
  logic          inv_s, inv_a, inv_n, inv_eff;
  logic          lvl, lvl_nx, reload;

  // A cfg_load coinciding with the boundary bypasses the shadow.
  always_comb begin
    duty_n   = cfg_load ? duty     : duty_s;
    hi_n     = cfg_load ? level_hi : hi_s;
    lo_n     = cfg_load ? level_lo : lo_s;
    inv_n    = cfg_load ? invert   : inv_s;
    reload   = 1'b0;
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else if (count_clk == '0) begin
      reload   = 1'b1;
      state_nx = (duty_n == '0) ? LOW : HIGH;
    end else if (state == HIGH && count_clk == duty_a) begin
      state_nx = LOW;
    end
    hi_eff  = reload ? hi_n  : hi_a;
    lo_eff  = reload ? lo_n  : lo_a;
    inv_eff = reload ? inv_n : inv_a;
    lvl_nx  = (state_nx == HIGH) ^ inv_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      duty_s     <= DUTY_DEF;
      hi_s       <= HI_DEF;
      lo_s       <= LO_DEF;
      inv_s      <= 1'b0;
      duty_a     <= DUTY_DEF;
      hi_a       <= HI_DEF;
      lo_a       <= LO_DEF;
      inv_a      <= 1'b0;
      lvl        <= 1'b0;
      out_square <= MID;
      edge_rise  <= 1'b0;
      edge_fall  <= 1'b0;
    end else begin
      if (cfg_load) begin
        duty_s <= duty;
        hi_s   <= level_hi;
        lo_s   <= level_lo;
        inv_s  <= invert;
      end
      if (reload) begin
        duty_a <= duty_n;
        hi_a   <= hi_n;
        lo_a   <= lo_n;
        inv_a  <= inv_n;
      end
      state <= state_nx;
      lvl   <= lvl_nx;
      // Edges compare logical levels, so equal hi/lo values still pulse; IDLE never does.
      if (state_nx == IDLE) begin
        out_square <= MID;
        edge_rise  <= 1'b0;
        edge_fall  <= 1'b0;
      end else begin
        out_square <= lvl_nx ? hi_eff : lo_eff;
        edge_rise  <= (state != IDLE) && !lvl && lvl_nx;
        edge_fall  <= (state != IDLE) && lvl && !lvl_nx;
      end
    end
  end

endmodule

// File: tb/tb_square_pwm_gen.sv
// Directed bench for square_pwm_gen driven by a free-running 8-bit phase counter.
module tb_square_pwm_gen;
  logic       clk = 1'b0;
  logic       rst, en, cfg_load, invert;
  logic [7:0] count_clk, duty, level_hi, level_lo;
  logic [7:0] out_square;
  logic       edge_rise, edge_fall;
  logic [9:0] e;
  int         checks = 0;
  int         failures = 0;
  int         last;

  always #5 clk = ~clk;

  square_pwm_gen #(.W(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .count_clk(count_clk), .cfg_load(cfg_load),
    .duty(duty), .level_hi(level_hi), .level_lo(level_lo), .invert(invert),
    .out_square(out_square), .edge_rise(edge_rise), .edge_fall(edge_fall)
  );

  // One clock; 'last' is the count value the DUT sampled at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    last = count_clk;
    count_clk = count_clk + 8'd1;
  endtask

  // Expected {out, rise, fall} at count k; prev = logical level before k==0 (2 = from IDLE).
  function automatic logic [9:0] exp_vec(input int k, input int d, input logic [7:0] hi,
                                         input logic [7:0] lo, input logic inv, input int prev);
    logic cur, pre, valid;
    cur = ((k < d) ? 1'b1 : 1'b0) ^ inv;
    if (k == 0) begin
      valid = (prev != 2);
      pre   = (prev == 1);
    end else begin
      valid = 1'b1;
      pre   = (((k - 1) < d) ? 1'b1 : 1'b0) ^ inv;
    end
    return {cur ? hi : lo, valid & ~pre & cur, valid & pre & ~cur};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; invert = 1'b0;
    duty = 8'd0; level_hi = 8'd0; level_lo = 8'd0; count_clk = 8'd200;
    #2;
    checks++;
    if ({out_square, edge_rise, edge_fall} !== {8'h80, 2'b00}) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", {out_square, edge_rise, edge_fall}, {8'h80, 2'b00});
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({out_square, edge_rise, edge_fall} !== {8'h80, 2'b00}) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", {out_square, edge_rise, edge_fall}, {8'h80, 2'b00});
    end
  endtask

  task automatic test_default_square();
    en = 1'b1;
    for (int i = 0; i < 256 && count_clk != 8'd0; i++) begin
      tick();
      checks++;
      if ({out_square, edge_rise, edge_fall} !== {8'h80, 2'b00}) begin
        failures++;
        $display("FAIL prestart k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, {8'h80, 2'b00});
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) begin
        tick();
        e = exp_vec(last, 128, 8'hFE, 8'h01, 1'b0, (p == 0) ? 2 : 0);
        checks++;
        if ({out_square, edge_rise, edge_fall} !== e) begin
          failures++;
          $display("FAIL default p=%0d k=%0d got=%h exp=%h", p, last, {out_square, edge_rise, edge_fall}, e);
        end
      end
    end
  endtask

  task automatic test_cfg_midperiod();
    for (int i = 0; i < 256; i++) begin
      cfg_load = (count_clk == 8'd10);
      if (cfg_load) begin duty = 8'd64; level_hi = 8'hC0; level_lo = 8'h40; invert = 1'b0; end
      tick();
      e = exp_vec(last, 128, 8'hFE, 8'h01, 1'b0, 0);
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL cfg_hold k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, e);
      end
    end
    for (int i = 0; i < 256; i++) begin
      cfg_load = 1'b0;
      tick();
      e = exp_vec(last, 64, 8'hC0, 8'h40, 1'b0, 0);
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL cfg_new k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, e);
      end
    end
  endtask

  task automatic test_duty_extremes();
    for (int i = 0; i < 256; i++) begin
      cfg_load = (count_clk == 8'd5);
      if (cfg_load) begin duty = 8'd0; level_hi = 8'hFE; level_lo = 8'h01; invert = 1'b0; end
      tick();
      e = exp_vec(last, 64, 8'hC0, 8'h40, 1'b0, 0);
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL duty_pre k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, e);
      end
    end
    for (int i = 0; i < 256; i++) begin
      cfg_load = (count_clk == 8'd5);
      if (cfg_load) duty = 8'd255;
      tick();
      e = exp_vec(last, 0, 8'hFE, 8'h01, 1'b0, 0);
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL duty0 k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, e);
      end
    end
    cfg_load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) begin
        tick();
        e = exp_vec(last, 255, 8'hFE, 8'h01, 1'b0, 0);
        checks++;
        if ({out_square, edge_rise, edge_fall} !== e) begin
          failures++;
          $display("FAIL duty255 p=%0d k=%0d got=%h exp=%h", p, last, {out_square, edge_rise, edge_fall}, e);
        end
      end
    end
  endtask

  task automatic test_invert_boundary();
    for (int i = 0; i < 256; i++) begin
      cfg_load = (count_clk == 8'd0);
      if (cfg_load) begin duty = 8'd128; level_hi = 8'hFE; level_lo = 8'h01; invert = 1'b1; end
      tick();
      e = exp_vec(last, 128, 8'hFE, 8'h01, 1'b1, 0);
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL invert k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, e);
      end
    end
    cfg_load = 1'b0;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 256; i++) begin
      if (count_clk == 8'd50) en = 1'b0;
      if (count_clk == 8'd200) en = 1'b1;
      cfg_load = (count_clk == 8'd100);
      if (cfg_load) begin duty = 8'd100; level_hi = 8'hF0; level_lo = 8'h10; invert = 1'b0; end
      tick();
      e = (last < 50) ? exp_vec(last, 128, 8'hFE, 8'h01, 1'b1, 1) : {8'h80, 2'b00};
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL enable k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, e);
      end
    end
    cfg_load = 1'b0;
    for (int i = 0; i < 257; i++) begin
      tick();
      e = exp_vec(last, 100, 8'hF0, 8'h10, 1'b0, (i == 0) ? 2 : 0);
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL restart i=%0d k=%0d got=%h exp=%h", i, last, {out_square, edge_rise, edge_fall}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_square, edge_rise, edge_fall} !== {8'h80, 2'b00}) begin
      failures++;
      $display("FAIL rst_async got=%h exp=%h", {out_square, edge_rise, edge_fall}, {8'h80, 2'b00});
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 256 && count_clk != 8'd0; i++) begin
      tick();
      checks++;
      if ({out_square, edge_rise, edge_fall} !== {8'h80, 2'b00}) begin
        failures++;
        $display("FAIL rst_idle k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, {8'h80, 2'b00});
      end
    end
    for (int i = 0; i < 131; i++) begin
      tick();
      e = exp_vec(last, 128, 8'hFE, 8'h01, 1'b0, 2);
      checks++;
      if ({out_square, edge_rise, edge_fall} !== e) begin
        failures++;
        $display("FAIL rst_defaults k=%0d got=%h exp=%h", last, {out_square, edge_rise, edge_fall}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_square();
    test_cfg_midperiod();
    test_duty_extremes();
    test_invert_boundary();
    test_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
